// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Contents: FSM state encodings, the default frame marker and the word address helper.
package imem_boot_loader_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_LEN0  = 3'd1;
   localparam state_t ST_LEN1  = 3'd2;
   localparam state_t ST_DATA  = 3'd3;
   localparam state_t ST_WRITE = 3'd4;
   localparam state_t ST_CSUM  = 3'd5;
   localparam state_t ST_DONE  = 3'd6;
   localparam state_t ST_ERR   = 3'd7;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   // Byte address of word idx; idx never exceeds DEPTH, so no wrap is possible.
   function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
      return base + {14'd0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream receive handshake plus instruction memory write port.
// The host/bench side uses master; the loader uses slave.
interface imem_boot_loader_if;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;

   modport master (output rx_valid, rx_data, input rx_ready, mem_we, mem_addr, mem_wdata);
   modport slave  (input rx_valid, rx_data, output rx_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_word_assembler.sv
// Packs bytes little-endian into 32-bit words and keeps a running XOR of every byte pushed.
// word_o holds the last completed word until the next one completes.
module imem_word_assembler
   import imem_boot_loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clear_i,
   input  logic        push_i,
   input  logic [7:0]  byte_i,
   output logic        last_lane_o,
   output logic        word_ready_o,
   output logic [31:0] word_o,
   output logic [7:0]  csum_o
);

   logic [1:0]  idx_q;
   logic [23:0] shift_q;
   logic [31:0] word_q;
   logic [7:0]  csum_q;
   logic        ready_q;

   // Lane index, partial word, completed word and checksum.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idx_q   <= 2'd0;
         shift_q <= 24'd0;
         word_q  <= 32'd0;
         csum_q  <= 8'd0;
         ready_q <= 1'b0;
      end else if (clear_i) begin
         idx_q   <= 2'd0;
         shift_q <= 24'd0;
         csum_q  <= 8'd0;
         ready_q <= 1'b0;
      end else if (push_i) begin
         idx_q  <= idx_q + 2'd1;
         csum_q <= csum_q ^ byte_i;
         if (idx_q == 2'd3) begin
            word_q  <= {byte_i, shift_q};
            ready_q <= 1'b1;
         end else begin
            shift_q <= {byte_i, shift_q[23:8]};
            ready_q <= 1'b0;
         end
      end else begin
         ready_q <= 1'b0;
      end
   end

   assign last_lane_o  = (idx_q == 2'd3);
   assign word_ready_o = ready_q;
   assign word_o       = word_q;
   assign csum_o       = csum_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot controller: parses SYNC/LEN/data/CSUM frames, writes words into instruction memory,
// and holds the core in reset until an image loads with a matching checksum.
module imem_boot_loader
   import imem_boot_loader_pkg::*;
#(
   parameter int unsigned DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
   input  logic               clk_i,
   input  logic               rst_i,
   imem_boot_loader_if.slave  bus,
   output logic               cpu_rst_o,
   output logic               load_done_o,
   output logic               load_err_o,
   output logic [15:0]        word_count_o
);

   localparam logic [16:0] DEPTH_W = 17'(DEPTH);

   state_t      state_q, state_d;
   logic [15:0] len_q, len_d;
   logic [15:0] word_count_q, word_count_d;
   logic [31:0] addr_q, addr_d;
   logic        cpu_rst_q, cpu_rst_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        rx_ready_q, rx_ready_d;

   logic        xfer_s, is_sync_s;
   logic [15:0] len_n_s;
   logic        asm_clear_s, asm_push_s, asm_last_lane_s, asm_ready_s;
   logic [31:0] asm_word_s;
   logic [7:0]  asm_csum_s;

   assign xfer_s    = bus.rx_valid && rx_ready_q;
   assign is_sync_s = (bus.rx_data == SYNC_BYTE);
   assign len_n_s   = {bus.rx_data, len_q[7:0]};

   imem_word_assembler u_asm (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .clear_i      (asm_clear_s),
      .push_i       (asm_push_s),
      .byte_i       (bus.rx_data),
      .last_lane_o  (asm_last_lane_s),
      .word_ready_o (asm_ready_s),
      .word_o       (asm_word_s),
      .csum_o       (asm_csum_s)
   );

   // Frame FSM next-state and output decode.
   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      word_count_d = word_count_q;
      addr_d       = addr_q;
      cpu_rst_d    = cpu_rst_q;
      done_d       = done_q;
      err_d        = err_q;
      asm_clear_s  = 1'b0;
      asm_push_s   = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (xfer_s && is_sync_s) begin
               state_d      = ST_LEN0;
               word_count_d = 16'd0;
               cpu_rst_d    = 1'b1;
               done_d       = 1'b0;
               err_d        = 1'b0;
               asm_clear_s  = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         ST_LEN0: begin
            if (xfer_s) begin
               len_d   = {8'h00, bus.rx_data};
               state_d = ST_LEN1;
            end else begin
               state_d = state_q;
            end
         end
         ST_LEN1: begin
            if (xfer_s) begin
               len_d = len_n_s;
               if ((len_n_s == 16'd0) || ({1'b0, len_n_s} > DEPTH_W)) begin
                  state_d   = ST_ERR;
                  err_d     = 1'b1;
                  cpu_rst_d = 1'b1;
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_DATA: begin
            if (xfer_s) begin
               asm_push_s = 1'b1;
               if (asm_last_lane_s) begin
                  state_d = ST_WRITE;
                  addr_d  = word_addr(BASE_ADDR, word_count_q);
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               state_d = state_q;
            end
         end
         ST_WRITE: begin
            word_count_d = word_count_q + 16'd1;
            if ((word_count_q + 16'd1) == len_q) begin
               state_d = ST_CSUM;
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_CSUM: begin
            if (xfer_s) begin
               if (bus.rx_data == asm_csum_s) begin
                  state_d   = ST_DONE;
                  done_d    = 1'b1;
                  cpu_rst_d = 1'b0;
               end else begin
                  state_d   = ST_ERR;
                  err_d     = 1'b1;
                  cpu_rst_d = 1'b1;
               end
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      rx_ready_d = (state_d != ST_WRITE);
   end

   // State and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         len_q        <= 16'd0;
         word_count_q <= 16'd0;
         addr_q       <= BASE_ADDR;
         cpu_rst_q    <= 1'b1;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         rx_ready_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         word_count_q <= word_count_d;
         addr_q       <= addr_d;
         cpu_rst_q    <= cpu_rst_d;
         done_q       <= done_d;
         err_q        <= err_d;
         rx_ready_q   <= rx_ready_d;
      end
   end

   assign bus.rx_ready  = rx_ready_q;
   assign bus.mem_we    = asm_ready_s;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = asm_word_s;
   assign cpu_rst_o     = cpu_rst_q;
   assign load_done_o   = done_q;
   assign load_err_o    = err_q;
   assign word_count_o  = word_count_q;

endmodule
